// File: rtl/fp16_mac_result_buffer.sv
// Result buffer behind a fixed-latency FP16 MAC chain. It tracks issued operands with a
// valid shadow, captures mac_result into a first-word-fall-through FIFO and issues on credit only.
module fp16_mac_result_buffer #(
    parameter int LATENCY = 16,
    parameter int DEPTH   = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             mac_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             out_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic [$clog2(DEPTH):0]  inflight,
    output logic                    overflow_err
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1
    // and flush is 0. in_ready depends only on registered counts. out_valid depends only on level.

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t FULL    = cnt_t'(DEPTH);
    localparam cnt_t CNT_ONE = cnt_t'(1);
    localparam ptr_t PTR_ONE = ptr_t'(1);

    logic [LATENCY-1:0] shadow_q, shadow_d;
    cnt_t               level_q, level_d;
    cnt_t               inflight_q, inflight_d;
    ptr_t               wr_ptr_q, wr_ptr_d;
    ptr_t               rd_ptr_q, rd_ptr_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        out_data_q, out_data_d;
    logic [15:0]        mem [DEPTH];

    logic               issue;
    logic               pop;
    logic               capture;
    logic               push;
    logic               drop;
    logic [CW:0]        credit_used;

    assign credit_used = {1'b0, level_q} + {1'b0, inflight_q};
    assign in_ready    = credit_used < {1'b0, FULL};
    assign out_valid   = (level_q != '0);

    assign issue   = in_valid && in_ready && !flush;
    assign pop     = out_valid && out_ready && !flush;
    assign capture = shadow_q[LATENCY-1] && !flush;
    // A full FIFO can still take a capture when the head leaves on the same edge.
    assign push    = capture && ((level_q != FULL) || pop);
    assign drop    = capture && !push;

    always_comb begin
        shadow_d    = shadow_q;
        shadow_d[0] = issue;
        for (int i = 1; i < LATENCY; i++) begin
            shadow_d[i] = shadow_q[i-1];
        end

        inflight_d = inflight_q;
        if (issue && !capture) begin
            inflight_d = inflight_q + CNT_ONE;
        end else if (!issue && capture) begin
            inflight_d = inflight_q - CNT_ONE;
        end

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + CNT_ONE;
        end else if (pop && !push) begin
            level_d = level_q - CNT_ONE;
        end

        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        ovf_d    = ovf_q | drop;

        if (flush) begin
            shadow_d   = '0;
            inflight_d = '0;
            level_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end

        // Registered head: bypass the write when the new head is the entry landing this edge.
        out_data_d = out_data_q;
        if (level_d != '0) begin
            out_data_d = (push && (wr_ptr_q == rd_ptr_d)) ? mac_result : mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q   <= '0;
            inflight_q <= '0;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            shadow_q   <= shadow_d;
            inflight_q <= inflight_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem[wr_ptr_q] <= mac_result;
        end
    end

    assign out_data     = out_data_q;
    assign level        = level_q;
    assign inflight     = inflight_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_fp16_mac_result_buffer.sv
// Directed bench for fp16_mac_result_buffer: a tagged MAC-chain model feeds mac_result
// and a scoreboard queue checks every popped result in issue order.
module tb_fp16_mac_result_buffer;
    localparam int LAT = 16;
    localparam int DEP = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mac_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [5:0]  level;
    logic [5:0]  inflight;
    logic        overflow_err;

    always #5 clock = ~clock;

    fp16_mac_result_buffer #(.LATENCY(LAT), .DEPTH(DEP)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mac_result   (mac_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .level        (level),
        .inflight     (inflight),
        .overflow_err (overflow_err)
    );

    typedef struct {
        int          n;
        logic [15:0] base;
        int          exp_level;
        logic [15:0] exp_head;
    } vec_t;

    vec_t        vecs [5];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] exp_q [$];
    logic [15:0] pipe [LAT];
    logic [15:0] tag_ctr;
    logic [15:0] iss_tag;
    logic        iss_now;
    int          iss_cnt   = 0;
    int          pop_cnt   = 0;
    int          valid_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Observe the handshakes that the next rising edge will perform.
    task automatic monitor();
        iss_now = in_valid && in_ready && !flush && !reset;
        if (reset || flush) begin
            exp_q.delete();
        end else if (out_valid && out_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pop: got 0x%0h, required no output", out_data);
            end else begin
                chk("pop_order", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
            end
        end
        if (out_valid) valid_cnt++;
        if (iss_now) begin
            iss_tag = tag_ctr;
            tag_ctr = tag_ctr + 16'h1;
            iss_cnt++;
            exp_q.push_back(iss_tag);
        end
    endtask

    // One clock: monitor at negedge, then advance the MAC-chain model just after posedge.
    task automatic step();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0]    = iss_now ? iss_tag : 16'hDEAD;
        mac_result = pipe[LAT-1];
    endtask

    task automatic issue_n(input int n);
        int start  = iss_cnt;
        int budget = 0;
        in_valid = 1'b1;
        while ((iss_cnt - start) < n && budget < 200) begin
            step();
            budget++;
        end
        in_valid = 1'b0;
        chk("issue_count", iss_cnt - start, n);
    endtask

    task automatic settle();
        int budget = 0;
        while (inflight != 6'd0 && budget < 64) begin
            step();
            budget++;
        end
        chk("settle_inflight", {26'h0, inflight}, 32'h0);
    endtask

    task automatic drain();
        int budget = 0;
        out_ready = 1'b1;
        while (out_valid && budget < 100) begin
            step();
            budget++;
        end
        out_ready = 1'b0;
        chk("drain_empty", {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        int start;
        int p0;
        int p1;
        int v0;

        vecs[0] = '{n: 1, base: 16'h7E00, exp_level: 1, exp_head: 16'h7E00};
        vecs[1] = '{n: 1, base: 16'h0001, exp_level: 1, exp_head: 16'h0001};
        vecs[2] = '{n: 3, base: 16'hFFFE, exp_level: 3, exp_head: 16'hFFFE};
        vecs[3] = '{n: 5, base: 16'h8000, exp_level: 5, exp_head: 16'h8000};
        vecs[4] = '{n: 8, base: 16'h1234, exp_level: 8, exp_head: 16'h1234};

        reset      = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        mac_result = 16'h0;
        tag_ctr    = 16'h0;
        for (int i = 0; i < LAT; i++) pipe[i] = 16'h0;
        repeat (3) step();
        reset = 1'b0;

        chk("rst_in_ready",  {31'h0, in_ready},     32'h1);
        chk("rst_out_valid", {31'h0, out_valid},    32'h0);
        chk("rst_level",     {26'h0, level},        32'h0);
        chk("rst_inflight",  {26'h0, inflight},     32'h0);
        chk("rst_overflow",  {31'h0, overflow_err}, 32'h0);
        chk("rst_out_data",  {16'h0, out_data},     32'h0);

        // Single issue: result appears exactly LATENCY edges later.
        tag_ctr = 16'h3C00;
        issue_n(1);
        chk("single_inflight", {26'h0, inflight}, 32'h1);
        repeat (LAT - 1) step();
        chk("single_not_yet", {31'h0, out_valid}, 32'h0);
        step();
        chk("single_valid",    {31'h0, out_valid}, 32'h1);
        chk("single_data",     {16'h0, out_data},  32'h3C00);
        chk("single_level",    {26'h0, level},     32'h1);
        chk("single_inflight0", {26'h0, inflight}, 32'h0);
        drain();

        // Raw-bit patterns and burst sizes from the vector table.
        for (int v = 0; v < 5; v++) begin
            tag_ctr = vecs[v].base;
            issue_n(vecs[v].n);
            settle();
            chk("vec_level", {26'h0, level}, vecs[v].exp_level);
            chk("vec_head",  {16'h0, out_data}, {16'h0, vecs[v].exp_head});
            drain();
        end

        // Flush five edges after the last of 20 issues.
        tag_ctr = 16'h5000;
        issue_n(20);
        repeat (4) step();
        chk("preflush_level",    {26'h0, level},    32'd8);
        chk("preflush_inflight", {26'h0, inflight}, 32'd12);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_level",    {26'h0, level},     32'h0);
        chk("flush_inflight", {26'h0, inflight},  32'h0);
        chk("flush_in_ready", {31'h0, in_ready},  32'h1);
        chk("flush_valid",    {31'h0, out_valid}, 32'h0);
        out_ready = 1'b1;
        v0 = valid_cnt;
        repeat (2 * LAT) step();
        out_ready = 1'b0;
        chk("flush_no_leak", valid_cnt - v0, 0);

        // Reset with results both buffered and in flight.
        tag_ctr = 16'h6000;
        issue_n(12);
        repeat (11) step();
        chk("prerst_level",    {26'h0, level},    32'd7);
        chk("prerst_inflight", {26'h0, inflight}, 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_level",    {26'h0, level},        32'h0);
        chk("midrst_inflight", {26'h0, inflight},     32'h0);
        chk("midrst_valid",    {31'h0, out_valid},    32'h0);
        chk("midrst_out_data", {16'h0, out_data},     32'h0);
        out_ready = 1'b1;
        v0 = valid_cnt;
        repeat (2 * LAT) step();
        out_ready = 1'b0;
        chk("midrst_no_leak", valid_cnt - v0, 0);

        // Continuous issue into a stalled consumer: credit stops at DEPTH.
        tag_ctr  = 16'h0100;
        start    = iss_cnt;
        in_valid = 1'b1;
        repeat (60) step();
        chk("fill_issues",   iss_cnt - start, DEP);
        chk("fill_in_ready", {31'h0, in_ready},     32'h0);
        chk("fill_level",    {26'h0, level},        32'd32);
        chk("fill_overflow", {31'h0, overflow_err}, 32'h0);

        // Release the consumer: one result per cycle in issue order across pointer wrap.
        out_ready = 1'b1;
        p0 = pop_cnt;
        repeat (40) step();
        p1 = pop_cnt;
        repeat (20) step();
        chk("steady_rate", pop_cnt - p1, 20);
        chk("wrap_pops",   pop_cnt - p0, 60);
        in_valid = 1'b0;
        settle();
        drain();
        chk("sb_empty", exp_q.size(), 0);

        // Illegal capture into a full FIFO by overriding credit for one issue.
        tag_ctr = 16'hA000;
        issue_n(DEP);
        settle();
        chk("ovf_pre_level", {26'h0, level},    32'd32);
        chk("ovf_pre_ready", {31'h0, in_ready}, 32'h0);
        force dut.in_ready = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        release dut.in_ready;
        void'(exp_q.pop_back());
        repeat (LAT - 1) step();
        chk("ovf_not_yet", {31'h0, overflow_err}, 32'h0);
        step();
        chk("ovf_set",      {31'h0, overflow_err}, 32'h1);
        chk("ovf_level",    {26'h0, level},        32'd32);
        chk("ovf_head",     {16'h0, out_data},     32'hA000);
        chk("ovf_inflight", {26'h0, inflight},     32'h0);
        drain();
        chk("ovf_sb_empty", exp_q.size(), 0);
        chk("ovf_sticky",   {31'h0, overflow_err}, 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (3) step();
        chk("ovf_after_flush", {31'h0, overflow_err}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("ovf_cleared",   {31'h0, overflow_err}, 32'h0);
        chk("final_ready",   {31'h0, in_ready},     32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fp16_mac_result_buffer.md
FP16_MAC_RESULT_BUFFER -- requirements
Module: fp16_mac_result_buffer

Interface
REQ-001 The block SHALL take parameter LATENCY, default 16, meaning the fixed cycle count from operand issue into the two-stage half-precision MAC chain to its dataout.
REQ-002 The block SHALL take parameter DEPTH, default 32, meaning result FIFO entries; it is a power of two and at least LATENCY.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port flush, input, 1, synchronous discard of buffered and in-flight results.
REQ-006 The block SHALL have port in_valid, input, 1, upstream requests to issue one operand set to the MAC chain this cycle.
REQ-007 The block SHALL have port in_ready, output, 1, issue permitted this cycle.
REQ-008 The block SHALL have port mac_result, input, 16, MAC chain dataout (FP16 bits).
REQ-009 The block SHALL have port out_valid, output, 1, the FIFO head holds a result.
REQ-010 The block SHALL have port out_ready, input, 1, the consumer accepts the head this cycle.
REQ-011 The block SHALL have port out_data, output, 16, the FIFO head result.
REQ-012 The block SHALL have port level, output, $clog2(DEPTH)+1, the FIFO occupancy.
REQ-013 The block SHALL have port inflight, output, $clog2(DEPTH)+1, the count of issued results not yet captured.
REQ-014 The block SHALL have port overflow_err, output, 1, sticky error flag.

Function
REQ-015 An issue SHALL occur on a rising edge where in_valid and in_ready are both 1 and flush is 0.
REQ-016 A LATENCY-deep valid shadow shift register SHALL track issues; an issue at edge N SHALL cause mac_result to be written into the FIFO at edge N+LATENCY.
REQ-017 mac_result SHALL be stored as raw bits, with no arithmetic or NaN/denormal interpretation.
REQ-018 in_ready SHALL equal (level + inflight) < DEPTH, computed combinationally from registered counts; a pop in the same cycle is not credited until the next cycle.
REQ-019 inflight SHALL increment on issue, decrement on capture, and hold when both occur on the same edge.
REQ-020 The FIFO SHALL be first-word-fall-through: out_valid = (level != 0), and out_data = the head entry with no added read latency.
REQ-021 A pop SHALL occur when out_valid and out_ready are both 1; a simultaneous push and pop SHALL leave level unchanged and preserve order.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 A capture when level == DEPTH with no same-edge pop SHALL drop the result, leave the FIFO unchanged, and set overflow_err until reset; by REQ-018 this cannot occur in legal operation.
REQ-024 out_data SHALL hold its last value when out_valid is 0; consumers treat it as don't-care.
REQ-025 flush SHALL, on the edge it is sampled, clear the shadow register, inflight, level and pointers, block issue and pop that edge, and leave overflow_err unchanged.
REQ-026 Results of issues made before a flush SHALL never appear on out_data.
REQ-027 Back-to-back issues every cycle SHALL be sustained while credit remains; throughput is one result per cycle.

Reset
REQ-028 While reset is 1 at an edge, the block SHALL clear the shadow register, inflight, level, pointers and overflow_err; reset has priority over flush, issue and pop.
REQ-029 Reset SHALL not clear FIFO storage contents.
REQ-030 After reset, in_ready SHALL be 1, out_valid 0, level 0, inflight 0, overflow_err 0 and out_data 16'h0000.
REQ-031 Reset mid-operation SHALL discard all in-flight results; no pre-reset result appears afterwards.

Verification
REQ-032 Single issue at edge 10 with mac_result=16'h3C00 at edge 26 -> out_valid rises after edge 26, out_data=16'h3C00, level=1, inflight=0.
REQ-033 Continuous in_valid with out_ready=0 -> exactly 32 issues accepted, then in_ready=0, level reaches 32, overflow_err stays 0.
REQ-034 From full with out_ready=1 and in_valid=1 -> steady one result per cycle after refill, in strict issue order across pointer wrap (entries 0..40 verified).
REQ-035 20 issues, then flush at edge 5 after the last issue -> level=0 and inflight=0 next cycle, no flushed result ever output, in_ready=1.
REQ-036 Reset asserted with level=7 and inflight=5 -> all counts 0 after the edge, out_valid=0, no stale output for 2*LATENCY cycles.
REQ-037 Forced illegal capture at level=32 (bench overrides credit) -> overflow_err=1 and remains set until reset, FIFO contents unchanged.
